// File: rtl/riscv_v_lmul_sequencer.sv
// riscv_v_lmul_sequencer
//
// Issue-side controller for the vector element datapath. It accepts one decoded
// vector instruction with its vtype/vl/vstart snapshot. It then emits one beat
// per physical register of the LMUL register group, so the downstream decode
// element only ever sees single-register operands with a register-local
// length/start pair.
//
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   in_valid_i / in_ready_o   instruction handshake (ready only while idle)
//   in_vsew_i, in_vlmul_i     vtype fields (element size code, group size code)
//   in_vl_i, in_vstart_i      vector length and first element, in elements
//   in_vs1_i/vs2_i/vd_i       register group base addresses
//   out_valid_o / out_ready_i beat handshake
//   out_vs1_o/vs2_o/vd_o      per-beat register addresses (base + beat, wraps)
//   out_len_o, out_start_o    register-local vl / vstart for this beat
//   out_elem_base_o           global index of the beat's element 0
//   out_beat_o                beat index within the group
//   out_first_o, out_last_o   first / last emitted beat markers
//   done_o, illegal_o         one-cycle retire pulse; illegal qualifies done
module riscv_v_lmul_sequencer #(
  parameter int VLEN      = 128,
  parameter int NUM_VREGS = 32,
  parameter int VL_W      = $clog2(VLEN) + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [2:0]      in_vsew_i,
  input  logic [2:0]      in_vlmul_i,
  input  logic [VL_W-1:0] in_vl_i,
  input  logic [VL_W-1:0] in_vstart_i,
  input  logic [4:0]      in_vs1_i,
  input  logic [4:0]      in_vs2_i,
  input  logic [4:0]      in_vd_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [4:0]      out_vs1_o,
  output logic [4:0]      out_vs2_o,
  output logic [4:0]      out_vd_o,
  output logic [VL_W-1:0] out_len_o,
  output logic [VL_W-1:0] out_start_o,
  output logic [VL_W-1:0] out_elem_base_o,
  output logic [2:0]      out_beat_o,
  output logic            out_first_o,
  output logic            out_last_o,
  output logic            done_o,
  output logic            illegal_o
);

  // log2 of elements per register at the smallest element size (8 bits)
  localparam int EPR_LOG2 = $clog2(VLEN / 8);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [2:0]      beat_q, beat_d;
  logic [2:0]      b0_q, b0_d;
  logic [2:0]      b1_q, b1_d;
  logic [2:0]      epr_log2_q, epr_log2_d;
  logic [VL_W-1:0] vl_eff_q, vl_eff_d;
  logic [VL_W-1:0] vstart_q, vstart_d;
  logic [4:0]      vs1_q, vs1_d;
  logic [4:0]      vs2_q, vs2_d;
  logic [4:0]      vd_q, vd_d;
  logic            illegal_q, illegal_d;

  // Decode of the offered instruction, only used on the acceptance cycle
  logic            sew_legal;
  logic [2:0]      lmul_log2;
  logic [2:0]      dec_epr_log2;
  logic [3:0]      vlmax_log2;
  logic [VL_W-1:0] vlmax;
  logic [VL_W-1:0] dec_vl_eff;
  logic [4:0]      align_mask;
  logic            misaligned;
  logic            dec_illegal;
  logic            dec_zero;
  logic [2:0]      dec_b0;
  logic [2:0]      dec_b1;

  // EPR and LMUL are both powers of two, so all divisions become shifts.
  // b0/b1 are truncated to 3 bits; they only exceed that range when the
  // instruction has zero beats, in which case they are never used.
  always_comb begin
    sew_legal    = (in_vsew_i <= 3'd4);
    lmul_log2    = (in_vlmul_i <= 3'd3) ? in_vlmul_i : 3'd0;
    dec_epr_log2 = sew_legal ? (3'(EPR_LOG2) - in_vsew_i) : 3'd0;
    vlmax_log2   = {1'b0, dec_epr_log2} + {1'b0, lmul_log2};
    vlmax        = VL_W'(1) << vlmax_log2;
    dec_vl_eff   = (in_vl_i < vlmax) ? in_vl_i : vlmax;
    align_mask   = 5'((1 << lmul_log2) - 1);
    misaligned   = |((in_vs1_i | in_vs2_i | in_vd_i) & align_mask);
    dec_illegal  = !sew_legal || (in_vlmul_i == 3'd4) || misaligned;
    dec_zero     = (in_vstart_i >= dec_vl_eff);
    dec_b0       = 3'(in_vstart_i >> dec_epr_log2);
    dec_b1       = 3'((dec_vl_eff - VL_W'(1)) >> dec_epr_log2);
  end

  // Next-state logic: capture everything on acceptance, then walk the beat
  // counter from b0 to b1 one handshake at a time.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    b0_d       = b0_q;
    b1_d       = b1_q;
    epr_log2_d = epr_log2_q;
    vl_eff_d   = vl_eff_q;
    vstart_d   = vstart_q;
    vs1_d      = vs1_q;
    vs2_d      = vs2_q;
    vd_d       = vd_q;
    illegal_d  = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          beat_d     = dec_b0;
          b0_d       = dec_b0;
          b1_d       = dec_b1;
          epr_log2_d = dec_epr_log2;
          vl_eff_d   = dec_vl_eff;
          vstart_d   = in_vstart_i;
          vs1_d      = in_vs1_i;
          vs2_d      = in_vs2_i;
          vd_d       = in_vd_i;
          illegal_d  = dec_illegal;
          state_d    = (dec_illegal || dec_zero) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (out_ready_i) begin
          if (beat_q == b1_q) begin
            state_d = S_DONE;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any instruction in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      beat_q     <= '0;
      b0_q       <= '0;
      b1_q       <= '0;
      epr_log2_q <= '0;
      vl_eff_q   <= '0;
      vstart_q   <= '0;
      vs1_q      <= '0;
      vs2_q      <= '0;
      vd_q       <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      b0_q       <= b0_d;
      b1_q       <= b1_d;
      epr_log2_q <= epr_log2_d;
      vl_eff_q   <= vl_eff_d;
      vstart_q   <= vstart_d;
      vs1_q      <= vs1_d;
      vs2_q      <= vs2_d;
      vd_q       <= vd_d;
      illegal_q  <= illegal_d;
    end
  end

  // Per-beat register-local view. With all registers cleared by reset every
  // data output below evaluates to zero.
  logic [VL_W-1:0] elem_base;
  logic [VL_W-1:0] epr;
  logic [VL_W-1:0] beat_rem;

  assign elem_base = VL_W'(beat_q) << epr_log2_q;
  assign epr       = VL_W'(1) << epr_log2_q;
  assign beat_rem  = vl_eff_q - elem_base;

  assign in_ready_o      = (state_q == S_IDLE) && !rst_i;
  assign out_valid_o     = (state_q == S_ISSUE);
  assign out_vs1_o       = vs1_q + 5'(beat_q);
  assign out_vs2_o       = vs2_q + 5'(beat_q);
  assign out_vd_o        = vd_q + 5'(beat_q);
  assign out_len_o       = (beat_rem > epr) ? epr : beat_rem;
  assign out_start_o     = (vstart_q > elem_base) ? (vstart_q - elem_base) : '0;
  assign out_elem_base_o = elem_base;
  assign out_beat_o      = beat_q;
  assign out_first_o     = out_valid_o && (beat_q == b0_q);
  assign out_last_o      = out_valid_o && (beat_q == b1_q);
  assign done_o          = (state_q == S_DONE);
  assign illegal_o       = (state_q == S_DONE) && illegal_q;

endmodule

// File: tb/tb_riscv_v_lmul_sequencer.sv
// tb_riscv_v_lmul_sequencer
//
// Self-checking bench for riscv_v_lmul_sequencer. A behavioural model walks
// every register of the group and intersects its element window with
// [vstart, min(vl, VLMAX)) to build the list of expected beats.
module tb_riscv_v_lmul_sequencer;

  localparam int VLW = 8;

  typedef struct packed {
    logic [2:0]     vsew;
    logic [2:0]     vlmul;
    logic [VLW-1:0] vl;
    logic [VLW-1:0] vstart;
    logic [4:0]     vs1;
    logic [4:0]     vs2;
    logic [4:0]     vd;
  } instr_t;

  typedef struct packed {
    logic [4:0]     vs1;
    logic [4:0]     vs2;
    logic [4:0]     vd;
    logic [VLW-1:0] len;
    logic [VLW-1:0] start;
    logic [VLW-1:0] base;
    logic [2:0]     beat;
    logic           first;
    logic           last;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           inValid, inReady;
  logic [2:0]     inVsew, inVlmul;
  logic [VLW-1:0] inVl, inVstart;
  logic [4:0]     inVs1, inVs2, inVd;
  logic           outValid, outReady;
  logic [4:0]     outVs1, outVs2, outVd;
  logic [VLW-1:0] outLen, outStart, outElemBase;
  logic [2:0]     outBeat;
  logic           outFirst, outLast, doneO, illegalO;

  always #5 clk = ~clk;

  riscv_v_lmul_sequencer dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(inValid), .in_ready_o(inReady),
    .in_vsew_i(inVsew), .in_vlmul_i(inVlmul),
    .in_vl_i(inVl), .in_vstart_i(inVstart),
    .in_vs1_i(inVs1), .in_vs2_i(inVs2), .in_vd_i(inVd),
    .out_valid_o(outValid), .out_ready_i(outReady),
    .out_vs1_o(outVs1), .out_vs2_o(outVs2), .out_vd_o(outVd),
    .out_len_o(outLen), .out_start_o(outStart), .out_elem_base_o(outElemBase),
    .out_beat_o(outBeat), .out_first_o(outFirst), .out_last_o(outLast),
    .done_o(doneO), .illegal_o(illegalO)
  );

  int    checks = 0;
  int    failures = 0;
  beat_t expQ[$];
  beat_t gotQ[$];
  bit    expIll, acceptOk, sawDone, gotIllegal, bubble, readyAfter, doneAfter;
  int    doneGap;

  function automatic beat_t snapshot();
    return '{vs1: outVs1, vs2: outVs2, vd: outVd, len: outLen, start: outStart,
             base: outElemBase, beat: outBeat, first: outFirst, last: outLast};
  endfunction

  // Reference model: expected legality and beat list for one instruction
  function automatic void modelInstr(input instr_t ins);
    int lmul, epr, vlEff, lo, s, e;
    expQ.delete();
    lmul   = (ins.vlmul <= 3) ? (1 << ins.vlmul) : 1;
    expIll = (ins.vsew > 4) || (ins.vlmul == 4) || (int'(ins.vs1) % lmul != 0) ||
             (int'(ins.vs2) % lmul != 0) || (int'(ins.vd) % lmul != 0);
    if (expIll) return;
    epr   = 16 >> ins.vsew;
    vlEff = (int'(ins.vl) < lmul * epr) ? int'(ins.vl) : lmul * epr;
    for (int b = 0; b < lmul; b++) begin
      lo = b * epr;
      s  = (int'(ins.vstart) > lo) ? int'(ins.vstart) : lo;
      e  = (vlEff < lo + epr) ? vlEff : lo + epr;
      if (s < e) begin
        expQ.push_back('{vs1: 5'(int'(ins.vs1) + b), vs2: 5'(int'(ins.vs2) + b),
                         vd: 5'(int'(ins.vd) + b), len: VLW'(e - lo), start: VLW'(s - lo),
                         base: VLW'(lo), beat: 3'(b), first: 1'b0, last: 1'b0});
      end
    end
    if (expQ.size() > 0) begin
      expQ[0].first = 1'b1;
      expQ[expQ.size() - 1].last = 1'b1;
    end
  endfunction

  // Offers an instruction and returns one cycle after the acceptance edge.
  // Inputs are scrambled afterwards so a design that fails to capture shows it.
  task automatic acceptInstr(input instr_t ins, output bit ok);
    int waitCyc = 0;
    inVsew = ins.vsew; inVlmul = ins.vlmul; inVl = ins.vl; inVstart = ins.vstart;
    inVs1 = ins.vs1; inVs2 = ins.vs2; inVd = ins.vd;
    inValid = 1'b1;
    while (!inReady && waitCyc < 50) begin
      @(posedge clk); #1;
      waitCyc++;
    end
    ok = inReady;
    @(posedge clk); #1;
    inValid = 1'b0;
    inVsew = 3'($urandom); inVlmul = 3'($urandom); inVl = 8'($urandom);
    inVstart = 8'($urandom); inVs1 = 5'($urandom); inVs2 = 5'($urandom); inVd = 5'($urandom);
  endtask

  // Runs one instruction to completion with random backpressure and records
  // what the design emitted. doneGap counts cycles from the last handshake
  // (or acceptance) to the done pulse.
  task automatic runInstr(input instr_t ins, input int stallPct);
    int cyc = 1;
    int lastHs = 0;
    bit ok;
    gotQ.delete();
    sawDone = 0; gotIllegal = 0; bubble = 0; doneGap = -1;
    outReady = 1'b0;
    acceptInstr(ins, ok);
    acceptOk = ok;
    while (cyc < 300) begin
      if (doneO) begin
        sawDone = 1; gotIllegal = illegalO; doneGap = cyc - lastHs;
        outReady = 1'b0;
        break;
      end
      if (outValid) begin
        outReady = ($urandom_range(0, 99) >= stallPct);
        if (outReady) begin
          gotQ.push_back(snapshot());
          lastHs = cyc;
        end
      end else begin
        outReady = 1'b0;
        bubble = 1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    @(posedge clk); #1;
    readyAfter = inReady;
    doneAfter  = doneO;
  endtask

  task automatic test_reset();
    rst = 1'b1; inValid = 1'b0; outReady = 1'b0;
    inVsew = '0; inVlmul = '0; inVl = '0; inVstart = '0; inVs1 = '0; inVs2 = '0; inVd = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({inReady, outValid, doneO, illegalO} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_ctrl got rdy/vld/done/ill=%b exp=0000", {inReady, outValid, doneO, illegalO});
    end
    checks++;
    if (snapshot() !== beat_t'(0)) begin
      failures++;
      $display("[TB] FAIL reset_data got=%h exp=0", snapshot());
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (inReady !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_release_ready got=%b exp=1", inReady);
    end
  endtask

  // Exact values for the worked examples, written as constants
  task automatic test_plan_values();
    instr_t ins;
    beat_t  want;
    int lenA[4]   = '{4, 4, 4, 1};
    int startB[3] = '{2, 0, 0};
    int lenB[3]   = '{4, 4, 1};
    ins = '{vsew: 3'd2, vlmul: 3'd2, vl: 8'd13, vstart: 8'd0, vs1: 5'd0, vs2: 5'd8, vd: 5'd4};
    runInstr(ins, 0);
    checks++;
    if (gotQ.size() !== 4) begin
      failures++;
      $display("[TB] FAIL plan_a_count got=%0d exp=4", gotQ.size());
    end
    for (int i = 0; i < 4 && i < gotQ.size(); i++) begin
      want = '{vs1: 5'(i), vs2: 5'(8 + i), vd: 5'(4 + i), len: 8'(lenA[i]), start: 8'd0,
               base: 8'(4 * i), beat: 3'(i), first: (i == 0), last: (i == 3)};
      checks++;
      if (gotQ[i] !== want) begin
        failures++;
        $display("[TB] FAIL plan_a_beat%0d got=%h exp=%h", i, gotQ[i], want);
      end
    end
    checks++;
    if (doneGap !== 1 || gotIllegal !== 1'b0) begin
      failures++;
      $display("[TB] FAIL plan_a_done got gap=%0d ill=%b exp gap=1 ill=0", doneGap, gotIllegal);
    end
    ins.vstart = 8'd6;
    runInstr(ins, 0);
    checks++;
    if (gotQ.size() !== 3) begin
      failures++;
      $display("[TB] FAIL plan_b_count got=%0d exp=3", gotQ.size());
    end
    for (int i = 0; i < 3 && i < gotQ.size(); i++) begin
      want = '{vs1: 5'(i + 1), vs2: 5'(9 + i), vd: 5'(5 + i), len: 8'(lenB[i]), start: 8'(startB[i]),
               base: 8'(4 * (i + 1)), beat: 3'(i + 1), first: (i == 0), last: (i == 2)};
      checks++;
      if (gotQ[i] !== want) begin
        failures++;
        $display("[TB] FAIL plan_b_beat%0d got=%h exp=%h", i, gotQ[i], want);
      end
    end
    ins = '{vsew: 3'd0, vlmul: 3'd0, vl: 8'd200, vstart: 8'd0, vs1: 5'd3, vs2: 5'd2, vd: 5'd1};
    runInstr(ins, 0);
    want = '{vs1: 5'd3, vs2: 5'd2, vd: 5'd1, len: 8'd16, start: 8'd0, base: 8'd0,
             beat: 3'd0, first: 1'b1, last: 1'b1};
    checks++;
    if (gotQ.size() !== 1 || gotQ[0] !== want) begin
      failures++;
      $display("[TB] FAIL plan_clamp got n=%0d beat=%h exp n=1 beat=%h", gotQ.size(),
               (gotQ.size() > 0) ? gotQ[0] : beat_t'(0), want);
    end
  endtask

  // Directed corner cases (zero-beat, illegal) checked against the model
  task automatic test_directed();
    instr_t tab[6];
    tab[0] = '{vsew: 3'd2, vlmul: 3'd2, vl: 8'd0,  vstart: 8'd0,  vs1: 5'd0, vs2: 5'd8, vd: 5'd4};
    tab[1] = '{vsew: 3'd2, vlmul: 3'd2, vl: 8'd13, vstart: 8'd13, vs1: 5'd0, vs2: 5'd8, vd: 5'd4};
    tab[2] = '{vsew: 3'd2, vlmul: 3'd4, vl: 8'd4,  vstart: 8'd0,  vs1: 5'd0, vs2: 5'd8, vd: 5'd4};
    tab[3] = '{vsew: 3'd2, vlmul: 3'd2, vl: 8'd13, vstart: 8'd0,  vs1: 5'd0, vs2: 5'd8, vd: 5'd5};
    tab[4] = '{vsew: 3'd6, vlmul: 3'd0, vl: 8'd4,  vstart: 8'd0,  vs1: 5'd0, vs2: 5'd8, vd: 5'd4};
    tab[5] = '{vsew: 3'd3, vlmul: 3'd6, vl: 8'd9,  vstart: 8'd1,  vs1: 5'd7, vs2: 5'd3, vd: 5'd31};
    for (int n = 0; n < 6; n++) begin
      modelInstr(tab[n]);
      runInstr(tab[n], 20);
      checks++;
      if (!acceptOk || !sawDone || doneGap !== 1) begin
        failures++;
        $display("[TB] FAIL dir%0d_timing got acc=%b done=%b gap=%0d exp acc=1 done=1 gap=1", n, acceptOk, sawDone, doneGap);
      end
      checks++;
      if (gotIllegal !== expIll) begin
        failures++;
        $display("[TB] FAIL dir%0d_illegal got=%b exp=%b", n, gotIllegal, expIll);
      end
      checks++;
      if (gotQ.size() !== expQ.size()) begin
        failures++;
        $display("[TB] FAIL dir%0d_count got=%0d exp=%0d", n, gotQ.size(), expQ.size());
      end
      for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
        checks++;
        if (gotQ[i] !== expQ[i]) begin
          failures++;
          $display("[TB] FAIL dir%0d_beat%0d got=%h exp=%h", n, i, gotQ[i], expQ[i]);
        end
      end
      checks++;
      if (readyAfter !== 1'b1 || doneAfter !== 1'b0) begin
        failures++;
        $display("[TB] FAIL dir%0d_retire got rdy=%b done=%b exp rdy=1 done=0", n, readyAfter, doneAfter);
      end
    end
  endtask

  // Beat 1 stalled for three cycles, then reset lands in the middle of beat 2
  task automatic test_backpressure_reset();
    instr_t ins;
    bit ok;
    ins = '{vsew: 3'd2, vlmul: 3'd2, vl: 8'd13, vstart: 8'd0, vs1: 5'd0, vs2: 5'd8, vd: 5'd4};
    modelInstr(ins);
    outReady = 1'b1;
    acceptInstr(ins, ok);
    checks++;
    if (!ok || outValid !== 1'b1 || snapshot() !== expQ[0]) begin
      failures++;
      $display("[TB] FAIL bp_beat0 got acc=%b vld=%b beat=%h exp acc=1 vld=1 beat=%h", ok, outValid, snapshot(), expQ[0]);
    end
    @(posedge clk); #1;
    outReady = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (outValid !== 1'b1 || snapshot() !== expQ[1]) begin
        failures++;
        $display("[TB] FAIL bp_hold%0d got vld=%b beat=%h exp vld=1 beat=%h", k, outValid, snapshot(), expQ[1]);
      end
      if (k == 3) outReady = 1'b1;
      @(posedge clk); #1;
    end
    outReady = 1'b0;
    checks++;
    if (outValid !== 1'b1 || snapshot() !== expQ[2]) begin
      failures++;
      $display("[TB] FAIL bp_beat2 got vld=%b beat=%h exp vld=1 beat=%h", outValid, snapshot(), expQ[2]);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({outValid, doneO, inReady} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL mid_reset got vld/done/rdy=%b exp=000", {outValid, doneO, inReady});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({inReady, outValid, doneO} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL post_reset got rdy/vld/done=%b exp=100", {inReady, outValid, doneO});
    end
  endtask

  task automatic test_random();
    instr_t ins;
    int lmulG, eprG, vlmaxG, vlI, vsI;
    for (int n = 0; n < 150; n++) begin
      ins.vsew  = ($urandom_range(0, 9) != 0) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      ins.vlmul = 3'($urandom_range(0, 7));
      if (ins.vlmul == 3'd4 && $urandom_range(0, 3) != 0) ins.vlmul = 3'd1;
      lmulG  = (ins.vlmul <= 3) ? (1 << ins.vlmul) : 1;
      eprG   = (ins.vsew <= 4) ? (16 >> ins.vsew) : 16;
      vlmaxG = lmulG * eprG;
      vlI = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, vlmaxG + 2));
      if (vlI > 255) vlI = 255;
      vsI = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, vlI + 1));
      if (vsI > 255) vsI = 255;
      ins.vl = 8'(vlI);
      ins.vstart = 8'(vsI);
      ins.vs1 = 5'($urandom_range(0, 31));
      ins.vs2 = 5'($urandom_range(0, 31));
      ins.vd  = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 9) != 0) begin
        ins.vs1 = ins.vs1 & 5'(~(lmulG - 1));
        ins.vs2 = ins.vs2 & 5'(~(lmulG - 1));
        ins.vd  = ins.vd & 5'(~(lmulG - 1));
      end
      modelInstr(ins);
      runInstr(ins, 30);
      checks++;
      if (!acceptOk || !sawDone || doneGap !== 1 || bubble) begin
        failures++;
        $display("[TB] FAIL rnd%0d_timing got acc=%b done=%b gap=%0d bubble=%b exp 1/1/1/0", n, acceptOk, sawDone, doneGap, bubble);
      end
      checks++;
      if (gotIllegal !== expIll) begin
        failures++;
        $display("[TB] FAIL rnd%0d_illegal got=%b exp=%b instr=%h", n, gotIllegal, expIll, ins);
      end
      checks++;
      if (gotQ.size() !== expQ.size()) begin
        failures++;
        $display("[TB] FAIL rnd%0d_count got=%0d exp=%0d instr=%h", n, gotQ.size(), expQ.size(), ins);
      end
      for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
        checks++;
        if (gotQ[i] !== expQ[i]) begin
          failures++;
          $display("[TB] FAIL rnd%0d_beat%0d got=%h exp=%h instr=%h", n, i, gotQ[i], expQ[i], ins);
        end
      end
      checks++;
      if (readyAfter !== 1'b1 || doneAfter !== 1'b0) begin
        failures++;
        $display("[TB] FAIL rnd%0d_retire got rdy=%b done=%b exp rdy=1 done=0", n, readyAfter, doneAfter);
      end
    end
  endtask

  initial begin
    test_reset();
    test_plan_values();
    test_directed();
    test_backpressure_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
